// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, PC reset/increment
// constants and the instruction word written into IF/ID when it is cleared.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam int PC_INCR   = 4;
    localparam int RESET_PC  = 0;
    localparam int RESET_NPC = 4;

    // sethi 0, %g0 -- the canonical SPARC nop
    localparam logic [31:0] NOP_INSTR = 32'h0100_0000;

endpackage

// File: rtl/npc_select.sv
// Combinational priority mux choosing next PC/nPC and the IF/ID and bubble controls.
// Event flags for the performance counters exist only when FETCH_PERF_CNT_EN is defined.
module npc_select
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              R,
    input  fetch_state_e      state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] npc,
    input  logic              stall_req,
    input  logic              ID_B_instr,
    input  logic              ID_29_a,
    input  logic              ID_cond_true,
    input  logic              ID_cond_always,
    input  logic [ADDR_W-1:0] ID_target,
    input  logic              ID_Call_instr,
    input  logic              EX_jmpl_instr,
    input  logic [ADDR_W-1:0] EX_jmpl_target,
    output logic [ADDR_W-1:0] pc_nxt,
    output logic [ADDR_W-1:0] npc_nxt,
    output logic              if_id_le,
    output logic              if_id_clr,
    output logic              ctrl_nop,
    output logic              stall_take
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic              annul,
    output logic              redirect
`endif
);

    logic [ADDR_W-1:0] id_tgt;
    logic [ADDR_W-1:0] jmpl_tgt;
    logic              taken;
    logic              annul_w;
    logic              redirect_w;

    assign id_tgt   = {ID_target[ADDR_W-1:2], 2'b00};
    assign jmpl_tgt = {EX_jmpl_target[ADDR_W-1:2], 2'b00};
    assign taken    = (ID_B_instr & (ID_cond_true | ID_cond_always)) | ID_Call_instr;

    always_comb begin
        pc_nxt     = npc;
        npc_nxt    = npc + ADDR_W'(PC_INCR);
        if_id_le   = 1'b1;
        if_id_clr  = 1'b0;
        ctrl_nop   = 1'b0;
        stall_take = 1'b0;
        annul_w    = 1'b0;
        redirect_w = 1'b0;
        if (R) begin
            pc_nxt    = ADDR_W'(RESET_PC);
            npc_nxt   = ADDR_W'(RESET_NPC);
            if_id_clr = 1'b1;
            ctrl_nop  = 1'b1;
        end else if (state == ST_BOOT) begin
            if_id_clr = 1'b1;
            ctrl_nop  = 1'b1;
        end else if (EX_jmpl_instr) begin
            // jmpl+8 is already in IF; the delay slot in ID carries on
            pc_nxt     = jmpl_tgt;
            npc_nxt    = jmpl_tgt + ADDR_W'(PC_INCR);
            if_id_clr  = 1'b1;
            redirect_w = 1'b1;
        end else if (stall_req) begin
            pc_nxt     = pc;
            npc_nxt    = npc;
            if_id_le   = 1'b0;
            ctrl_nop   = 1'b1;
            stall_take = 1'b1;
        end else if (taken) begin
            pc_nxt     = id_tgt;
            npc_nxt    = id_tgt + ADDR_W'(PC_INCR);
            redirect_w = 1'b1;
            // only ba,a annuls a taken delay slot
            if (ID_B_instr & ID_cond_always & ID_29_a) begin
                if_id_clr = 1'b1;
                annul_w   = 1'b1;
            end
        end else if (ID_B_instr & ID_29_a) begin
            if_id_clr = 1'b1;
            annul_w   = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    assign annul    = annul_w;
    assign redirect = redirect_w;
`endif

endmodule

// File: rtl/fetch_sequencer.sv
// PC/nPC owner for the fetch stage: delayed branches with annul, jmpl redirect, load-use stall.
// Define FETCH_PERF_CNT_EN to add the stall/annul/redirect performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | first cycle after reset, IF/ID cleared, sequential fetch
// ST_RUN  | normal fetch, next-PC priority rules applied
// ST_HOLD | load-use stall in progress, PC/nPC frozen, watchdog counting
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_STALL = 3
) (
    input  logic              Clk,
    input  logic              R,
    input  logic              stall_req,
    input  logic              ID_B_instr,
    input  logic              ID_29_a,
    input  logic              ID_cond_true,
    input  logic              ID_cond_always,
    input  logic [ADDR_W-1:0] ID_target,
    input  logic              ID_Call_instr,
    input  logic              EX_jmpl_instr,
    input  logic [ADDR_W-1:0] EX_jmpl_target,
    output logic [ADDR_W-1:0] PC_Out,
    output logic [ADDR_W-1:0] nPC_Out,
    output logic              IF_ID_LE,
    output logic              IF_ID_clr,
    output logic              ctrl_nop,
    output logic              stall_err
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       perf_stall,
    output logic [15:0]       perf_annul,
    output logic [15:0]       perf_redirect
`endif
);

    localparam int                CNT_W   = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_STALL + 1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] npc_nxt;
    logic              stall_take;
    logic [CNT_W-1:0]  stall_cnt;
`ifdef FETCH_PERF_CNT_EN
    logic              annul;
    logic              redirect;
`endif

    npc_select #(.ADDR_W(ADDR_W)) u_npc_select (
        .R              (R),
        .state          (state),
        .pc             (PC_Out),
        .npc            (nPC_Out),
        .stall_req      (stall_req),
        .ID_B_instr     (ID_B_instr),
        .ID_29_a        (ID_29_a),
        .ID_cond_true   (ID_cond_true),
        .ID_cond_always (ID_cond_always),
        .ID_target      (ID_target),
        .ID_Call_instr  (ID_Call_instr),
        .EX_jmpl_instr  (EX_jmpl_instr),
        .EX_jmpl_target (EX_jmpl_target),
        .pc_nxt         (pc_nxt),
        .npc_nxt        (npc_nxt),
        .if_id_le       (IF_ID_LE),
        .if_id_clr      (IF_ID_clr),
        .ctrl_nop       (ctrl_nop),
        .stall_take     (stall_take)
`ifdef FETCH_PERF_CNT_EN
        ,
        .annul          (annul),
        .redirect       (redirect)
`endif
    );

    always_ff @(posedge Clk) begin
        if (R) begin
            state     <= ST_BOOT;
            PC_Out    <= ADDR_W'(RESET_PC);
            nPC_Out   <= ADDR_W'(RESET_NPC);
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else begin
            PC_Out  <= pc_nxt;
            nPC_Out <= npc_nxt;
            if (state == ST_BOOT) begin
                state <= ST_RUN;
            end else if (stall_take) begin
                state <= ST_HOLD;
            end else begin
                state <= ST_RUN;
            end
            // stall_cnt counts consecutive stalled cycles, saturating one past the limit
            if (stall_take) begin
                if (stall_cnt != CNT_MAX) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
                if (stall_cnt >= CNT_W'(MAX_STALL)) begin
                    stall_err <= 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge Clk) begin
        if (R) begin
            perf_stall    <= '0;
            perf_annul    <= '0;
            perf_redirect <= '0;
        end else begin
            if (stall_take && perf_stall != 16'hFFFF) begin
                perf_stall <= perf_stall + 16'd1;
            end
            if (annul && perf_annul != 16'hFFFF) begin
                perf_annul <= perf_annul + 16'd1;
            end
            if (redirect && perf_redirect != 16'hFFFF) begin
                perf_redirect <= perf_redirect + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table followed by random stimulus
// compared against a cycle-level model of the fetch rules.
module tb_fetch_sequencer;

    localparam int ADDR_W    = 8;
    localparam int MAX_STALL = 3;

    logic              Clk = 1'b0;
    logic              R;
    logic              stall_req;
    logic              ID_B_instr;
    logic              ID_29_a;
    logic              ID_cond_true;
    logic              ID_cond_always;
    logic [ADDR_W-1:0] ID_target;
    logic              ID_Call_instr;
    logic              EX_jmpl_instr;
    logic [ADDR_W-1:0] EX_jmpl_target;
    logic [ADDR_W-1:0] PC_Out;
    logic [ADDR_W-1:0] nPC_Out;
    logic              IF_ID_LE;
    logic              IF_ID_clr;
    logic              ctrl_nop;
    logic              stall_err;

    fetch_sequencer #(.ADDR_W(ADDR_W), .MAX_STALL(MAX_STALL)) dut (
        .Clk            (Clk),
        .R              (R),
        .stall_req      (stall_req),
        .ID_B_instr     (ID_B_instr),
        .ID_29_a        (ID_29_a),
        .ID_cond_true   (ID_cond_true),
        .ID_cond_always (ID_cond_always),
        .ID_target      (ID_target),
        .ID_Call_instr  (ID_Call_instr),
        .EX_jmpl_instr  (EX_jmpl_instr),
        .EX_jmpl_target (EX_jmpl_target),
        .PC_Out         (PC_Out),
        .nPC_Out        (nPC_Out),
        .IF_ID_LE       (IF_ID_LE),
        .IF_ID_clr      (IF_ID_clr),
        .ctrl_nop       (ctrl_nop),
        .stall_err      (stall_err)
    );

    always #5 Clk = ~Clk;

    // jmpl in EX together with a stall request is an illegal input combination
    always @(posedge Clk) begin
        if (R === 1'b0) begin
            assert (!(stall_req && EX_jmpl_instr))
                else $error("FAIL illegal_input: stall_req and EX_jmpl_instr both high");
        end
    end

    typedef struct {
        int r, st, b, a, ct, ca, tgt, call, jm, jt;
        int le, clr, nop;
        int pc, npc, err;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    // reference model state
    int m_pc, m_npc, m_boot, m_run, m_err;

    function automatic vec_t mk(int r, int st, int b, int a, int ct, int ca, int tgt,
                                int call, int jm, int jt, int le, int clr, int nop,
                                int pc, int npc, int err);
        vec_t v;
        v.r = r; v.st = st; v.b = b; v.a = a; v.ct = ct; v.ca = ca; v.tgt = tgt;
        v.call = call; v.jm = jm; v.jt = jt; v.le = le; v.clr = clr; v.nop = nop;
        v.pc = pc; v.npc = npc; v.err = err;
        return v;
    endfunction

    function automatic vec_t idle(int pc, int npc, int err);
        return mk(0,0,0,0,0,0,0,0,0,0, 1,0,0, pc,npc,err);
    endfunction

    function automatic vec_t stl(int pc, int npc, int err);
        return mk(0,1,0,0,0,0,0,0,0,0, 0,0,1, pc,npc,err);
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic run_cycle(input vec_t v, input string tag);
        R              = v.r[0];
        stall_req      = v.st[0];
        ID_B_instr     = v.b[0];
        ID_29_a        = v.a[0];
        ID_cond_true   = v.ct[0];
        ID_cond_always = v.ca[0];
        ID_target      = ADDR_W'(v.tgt);
        ID_Call_instr  = v.call[0];
        EX_jmpl_instr  = v.jm[0];
        EX_jmpl_target = ADDR_W'(v.jt);
        #4;
        check({tag, ".IF_ID_LE"},  int'(IF_ID_LE),  v.le);
        check({tag, ".IF_ID_clr"}, int'(IF_ID_clr), v.clr);
        check({tag, ".ctrl_nop"},  int'(ctrl_nop),  v.nop);
        @(posedge Clk);
        #1;
        check({tag, ".PC_Out"},    int'(PC_Out),    v.pc);
        check({tag, ".nPC_Out"},   int'(nPC_Out),   v.npc);
        check({tag, ".stall_err"}, int'(stall_err), v.err);
    endtask

    task automatic model_seq();
        m_pc  = m_npc;
        m_npc = (m_npc + 4) % 256;
    endtask

    // expected controls for this cycle and the state after the edge, straight from the fetch rules
    task automatic model_step(inout vec_t v);
        int t;
        if (v.r != 0) begin
            v.le = 1; v.clr = 1; v.nop = 1;
            m_pc = 0; m_npc = 4; m_boot = 1; m_run = 0; m_err = 0;
        end else if (m_boot != 0) begin
            v.le = 1; v.clr = 1; v.nop = 1;
            model_seq();
            m_boot = 0; m_run = 0;
        end else if (v.jm != 0) begin
            v.le = 1; v.clr = 1; v.nop = 0;
            t = (v.jt / 4) * 4;
            m_pc = t; m_npc = (t + 4) % 256; m_run = 0;
        end else if (v.st != 0) begin
            v.le = 0; v.clr = 0; v.nop = 1;
            if (m_run <= MAX_STALL) m_run++;
            if (m_run > MAX_STALL) m_err = 1;
        end else begin
            v.le = 1; v.nop = 0; m_run = 0;
            if ((v.b != 0 && (v.ct != 0 || v.ca != 0)) || v.call != 0) begin
                t = (v.tgt / 4) * 4;
                m_pc = t; m_npc = (t + 4) % 256;
                v.clr = (v.b != 0 && v.ca != 0 && v.a != 0) ? 1 : 0;
            end else begin
                v.clr = (v.b != 0 && v.a != 0) ? 1 : 0;
                model_seq();
            end
        end
        v.pc = m_pc; v.npc = m_npc; v.err = m_err;
    endtask

    initial begin
        vec_t v;
        int   prev_st;

        // r st b a ct ca tgt call jm jt | le clr nop | pc npc err
        vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,    1,1,1, 0,4,0));       // reset
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,    1,1,1, 4,8,0));       // boot
        vecs.push_back(idle(8,12,0));
        vecs.push_back(idle(12,16,0));
        vecs.push_back(mk(0,0,1,0,1,0,40,0,0,0,   1,0,0, 40,44,0));     // taken, a=0
        vecs.push_back(idle(44,48,0));
        vecs.push_back(mk(0,0,1,1,0,0,80,0,0,0,   1,1,0, 48,52,0));     // untaken, a=1
        vecs.push_back(idle(52,56,0));
        vecs.push_back(mk(0,0,1,1,0,1,40,0,0,0,   1,1,0, 40,44,0));     // ba,a
        vecs.push_back(mk(0,1,1,0,1,0,100,0,0,0,  0,0,1, 40,44,0));     // stall over branch
        vecs.push_back(mk(0,1,1,0,1,0,100,0,0,0,  0,0,1, 40,44,0));
        vecs.push_back(mk(0,0,1,0,1,0,100,0,0,0,  1,0,0, 100,104,0));   // branch resolves
        vecs.push_back(mk(0,0,1,1,1,0,35,0,0,0,   1,0,0, 32,36,0));     // bcc,a taken, target aligned
        vecs.push_back(mk(0,0,0,0,0,0,200,1,0,0,  1,0,0, 200,204,0));   // call
        vecs.push_back(stl(200,204,0));
        vecs.push_back(stl(200,204,0));
        vecs.push_back(stl(200,204,0));
        vecs.push_back(stl(200,204,1));                                 // fourth stall trips watchdog
        vecs.push_back(idle(204,208,1));
        vecs.push_back(mk(0,0,1,0,1,0,40,0,1,100, 1,1,0, 100,104,1));   // jmpl beats branch
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,103,  1,1,0, 100,104,1));   // jmpl target aligned
        vecs.push_back(stl(100,104,1));
        vecs.push_back(mk(1,1,0,0,0,0,0,0,0,0,    1,1,1, 0,4,0));       // reset mid-stall
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,    1,1,1, 4,8,0));       // boot
        vecs.push_back(stl(4,8,0));
        vecs.push_back(stl(4,8,0));
        vecs.push_back(stl(4,8,0));                                     // three stalls allowed
        vecs.push_back(idle(8,12,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,1,248,  1,1,0, 248,252,0));   // go near the top
        vecs.push_back(idle(252,0,0));                                  // wrap
        vecs.push_back(idle(0,4,0));
        vecs.push_back(idle(4,8,0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // random phase, started from reset so the model and DUT agree
        prev_st = 0;
        for (int i = 0; i < 800; i++) begin
            v = idle(0,0,0);
            v.r    = (i == 0 || $urandom_range(0, 49) == 0) ? 1 : 0;
            v.jm   = ($urandom_range(0, 9) == 0) ? 1 : 0;
            if (v.jm == 0) begin
                if (prev_st != 0) v.st = ($urandom_range(0, 9) < 7) ? 1 : 0;
                else              v.st = ($urandom_range(0, 4) == 0) ? 1 : 0;
            end
            v.b    = ($urandom_range(0, 2) == 0) ? 1 : 0;
            v.a    = int'($urandom_range(0, 1));
            v.ct   = int'($urandom_range(0, 1));
            v.ca   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            v.call = (v.b == 0 && $urandom_range(0, 7) == 0) ? 1 : 0;
            v.tgt  = int'($urandom_range(0, 255));
            v.jt   = int'($urandom_range(0, 255));
            prev_st = v.st;
            model_step(v);
            run_cycle(v, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
